// File: rtl/num_check.sv
`timescale 1ns/1ps
// AXI-Stream LFSR pattern checker: compares incoming beats against a local LFSR,
// checks TDEST and packet framing, and reports counters plus a pass/fail verdict.
module num_check #(
    parameter int                 TDATAW       = 32,
    parameter int                 TDESTW       = 4,
    parameter int                 LFSR_DW      = 32,
    parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 32'h0000_0001,
    parameter logic [LFSR_DW-1:0] LFSR_TAPS    = 32'h8020_0003,
    parameter int                 PKT_LEN      = 4,
    parameter int                 NUM_PKTS     = 4,
    parameter logic [TDESTW-1:0]  MY_DEST      = '0,
    parameter int                 STALL_EVERY  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic [15:0]       PKT_COUNT,
    output logic [15:0]       BEAT_COUNT,
    output logic [15:0]       ERR_COUNT,
    output logic              DONE,
    output logic              PASS,
    output logic [TDATAW-1:0] FIRST_ERR_DATA
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t               state, state_d;
    logic [LFSR_DW-1:0]   lfsr;
    logic [LFSR_DW-1:0]   lfsr_next;
    logic [IDX_W-1:0]     beat_idx;
    logic [15:0]          stall_cnt;
    logic                 stall_q;
    logic                 accept;
    logic                 start_go;
    logic                 at_end;
    logic                 beat_err;
    logic                 last_pkt;
    logic [15:0]          err_after;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign AXIS_S_TREADY = (state == S_RECV) && !stall_q;
    assign accept        = AXIS_S_TVALID && AXIS_S_TREADY;
    assign start_go      = START && (state != S_RECV);
    assign at_end        = (beat_idx == IDX_W'(PKT_LEN - 1));
    assign lfsr_next     = {lfsr[LFSR_DW-2:0], ^(lfsr & LFSR_TAPS)};
    assign beat_err      = accept && ((AXIS_S_TDATA[LFSR_DW-1:0] != lfsr) ||
                                      (AXIS_S_TDEST != MY_DEST) ||
                                      (AXIS_S_TLAST != at_end));
    assign last_pkt      = accept && AXIS_S_TLAST && (PKT_COUNT == 16'(NUM_PKTS - 1));
    assign err_after     = beat_err ? sat_inc(ERR_COUNT) : ERR_COUNT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (START) state_d = S_RECV;
            S_RECV:  if (last_pkt) state_d = S_DONE;
            S_DONE:  if (START) state_d = S_RECV;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr           <= LFSR_DEFAULT;
            beat_idx       <= '0;
            stall_cnt      <= '0;
            stall_q        <= 1'b0;
            PKT_COUNT      <= '0;
            BEAT_COUNT     <= '0;
            ERR_COUNT      <= '0;
            FIRST_ERR_DATA <= '0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
        end else if (start_go) begin
            lfsr           <= LFSR_DEFAULT;
            beat_idx       <= '0;
            stall_cnt      <= '0;
            stall_q        <= 1'b0;
            PKT_COUNT      <= '0;
            BEAT_COUNT     <= '0;
            ERR_COUNT      <= '0;
            FIRST_ERR_DATA <= '0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            if (accept) begin
                // LFSR advances on every beat so a single bad word does not shift the pattern
                lfsr       <= lfsr_next;
                BEAT_COUNT <= BEAT_COUNT + 16'd1;
                ERR_COUNT  <= err_after;
                if (beat_err && (ERR_COUNT == 16'd0))
                    FIRST_ERR_DATA <= AXIS_S_TDATA;
                if (AXIS_S_TLAST) begin
                    PKT_COUNT <= PKT_COUNT + 16'd1;
                    beat_idx  <= '0;
                end else begin
                    beat_idx  <= at_end ? '0 : beat_idx + IDX_W'(1);
                end
                if (STALL_EVERY != 0) begin
                    if (stall_cnt == 16'(STALL_EVERY - 1)) begin
                        stall_cnt <= '0;
                        stall_q   <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                if (last_pkt) begin
                    DONE <= 1'b1;
                    PASS <= (err_after == 16'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_num_check.sv
`timescale 1ns/1ps
// Bench for num_check: directed and randomized streams scored against a beat-level model.
module tb_num_check;

    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst, start, tvalid, tlast, sel;
    logic [31:0] tdata;
    logic [3:0]  tdest;

    logic        start0, start1, tv0, tv1, tr0, tr1, d0, d1, p0, p1;
    logic [15:0] pc0, pc1, bc0, bc1, ec0, ec1;
    logic [31:0] fe0, fe1;

    logic        tready, done, pass;
    logic [15:0] pc, bc, ec;
    logic [31:0] fe;

    always #5 clk = ~clk;

    assign start0 = start && !sel;
    assign start1 = start && sel;
    assign tv0    = tvalid && !sel;
    assign tv1    = tvalid && sel;
    assign tready = sel ? tr1 : tr0;
    assign done   = sel ? d1  : d0;
    assign pass   = sel ? p1  : p0;
    assign pc     = sel ? pc1 : pc0;
    assign bc     = sel ? bc1 : bc0;
    assign ec     = sel ? ec1 : ec0;
    assign fe     = sel ? fe1 : fe0;

    num_check u_dut (
        .CLK(clk), .RST(rst), .START(start0),
        .AXIS_S_TVALID(tv0), .AXIS_S_TREADY(tr0), .AXIS_S_TDATA(tdata),
        .AXIS_S_TLAST(tlast), .AXIS_S_TDEST(tdest),
        .PKT_COUNT(pc0), .BEAT_COUNT(bc0), .ERR_COUNT(ec0),
        .DONE(d0), .PASS(p0), .FIRST_ERR_DATA(fe0)
    );

    num_check #(.STALL_EVERY(2)) u_stall (
        .CLK(clk), .RST(rst), .START(start1),
        .AXIS_S_TVALID(tv1), .AXIS_S_TREADY(tr1), .AXIS_S_TDATA(tdata),
        .AXIS_S_TLAST(tlast), .AXIS_S_TDEST(tdest),
        .PKT_COUNT(pc1), .BEAT_COUNT(bc1), .ERR_COUNT(ec1),
        .DONE(d1), .PASS(p1), .FIRST_ERR_DATA(fe1)
    );

    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state
    bit          m_recv, m_stall, m_done, m_pass;
    logic [31:0] m_lfsr, m_first;
    int          m_idx, m_pkt, m_beat, m_err, m_acc, stall_every;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        bit fb;
        fb = ($countones(l & TAPS) % 2) == 1;
        return {l[30:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_lfsr = SEED; m_first = 0; m_idx = 0; m_pkt = 0; m_beat = 0;
        m_err = 0; m_acc = 0; m_stall = 0; m_done = 0; m_pass = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit l, input logic [3:0] dst);
        bit err;
        err = (d != m_lfsr) || (dst != 4'd0) || (l != (m_idx == 3));
        if (err) begin
            if (m_err == 0) m_first = d;
            if (m_err < 65535) m_err++;
        end
        m_lfsr = lfsr_step(m_lfsr);
        m_beat = (m_beat + 1) % 65536;
        if (l) begin
            m_pkt++;
            m_idx = 0;
        end else begin
            m_idx = (m_idx == 3) ? 0 : m_idx + 1;
        end
        m_acc++;
        m_stall = (stall_every != 0) && (m_acc % stall_every == 0);
        if (l && m_pkt == 4) begin
            m_recv = 0; m_done = 1; m_pass = (m_err == 0);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_pkt"},   32'(pc), 32'(m_pkt));
        chk({tag, "_beat"},  32'(bc), 32'(m_beat));
        chk({tag, "_err"},   32'(ec), 32'(m_err));
        chk({tag, "_first"}, fe, m_first);
        chk({tag, "_done"},  32'(done), 32'(m_done));
        chk({tag, "_pass"},  32'(pass), 32'(m_pass));
    endtask

    task automatic tick(output bit acc);
        bit exp_rdy, st;
        @(negedge clk);
        exp_rdy = m_recv && !m_stall;
        chk("tready", 32'(tready), 32'(exp_rdy));
        acc = tvalid && exp_rdy;
        st  = start;
        @(posedge clk);
        #1;
        m_stall = 0;
        if (st && !m_recv) begin
            model_clear();
            m_recv = 1;
        end else if (acc) begin
            model_beat(tdata, tlast, tdest);
        end
        check_outputs("cyc");
    endtask

    task automatic idle_tick();
        bit a;
        tick(a);
    endtask

    task automatic do_start();
        tvalid = 0;
        start  = 1;
        idle_tick();
        start  = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit l, input logic [3:0] dst);
        bit acc = 0;
        tdata = d; tlast = l; tdest = dst; tvalid = 1;
        for (int n = 0; n < 16 && !acc; n++) tick(acc);
        chk("accept_wait", 32'(acc), 32'd1);
    endtask

    task automatic run_stream(input int data_at, input int dest_at, input int last_at,
                              input bit rnd, input int gap_pct);
        logic [31:0] d;
        logic [3:0]  dst;
        bit          l;
        for (int i = 0; i < 64 && m_recv; i++) begin
            d = m_lfsr; l = (m_idx == 3); dst = 4'd0;
            if (i == data_at) d = 32'hDEAD_BEEF;
            if (i == dest_at) dst = 4'd1;
            if (i == last_at) l = !l;
            if (rnd) begin
                if ($urandom_range(7) == 0) d = d ^ (32'd1 << $urandom_range(31));
                if ($urandom_range(9) == 0) dst = 4'($urandom_range(15));
                if (i < 12 && $urandom_range(9) == 0) l = !l;
            end
            send_beat(d, l, dst);
            if (int'($urandom_range(99)) < gap_pct) begin
                tvalid = 0;
                idle_tick();
            end
        end
        tvalid = 0;
        idle_tick();
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        m_recv = 0;
        model_clear();
        chk("rst_tready", 32'(tready), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst = 0;
        idle_tick();
        idle_tick();
    endtask

    initial begin
        rst = 1; start = 0; tvalid = 0; tlast = 0; tdata = 0; tdest = 0; sel = 0;
        stall_every = 0; m_recv = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", 32'(tready), 32'd0);
        check_outputs("reset");
        @(negedge clk);
        rst = 0;
        idle_tick();

        // Clean run: 16 beats of the LFSR sequence, four packets
        do_start();
        run_stream(-1, -1, -1, 0, 0);
        chk("clean_pkt", 32'(pc), 32'd4);
        chk("clean_beat", 32'(bc), 32'd16);
        chk("clean_err", 32'(ec), 32'd0);
        chk("clean_done", 32'(done), 32'd1);
        chk("clean_pass", 32'(pass), 32'd1);
        chk("clean_tready", 32'(tready), 32'd0);

        // Corrupted data word on beat 2 of packet 0
        do_start();
        run_stream(2, -1, -1, 0, 30);
        chk("data_err", 32'(ec), 32'd1);
        chk("data_first", fe, 32'hDEAD_BEEF);
        chk("data_pass", 32'(pass), 32'd0);

        // Early TLAST on beat 2 of packet 0
        do_start();
        run_stream(-1, -1, 2, 0, 0);
        chk("early_last_err", 32'(ec), 32'd1);
        chk("early_last_beat", 32'(bc), 32'd15);

        // Missing TLAST at packet end: index rolls without a packet count
        do_start();
        run_stream(-1, -1, 3, 0, 0);
        chk("miss_last_err", 32'(ec), 32'd1);
        chk("miss_last_beat", 32'(bc), 32'd20);

        // Dest error alone, then dest+data on one beat
        do_start();
        run_stream(-1, 5, -1, 0, 0);
        chk("dest_err", 32'(ec), 32'd1);
        do_start();
        run_stream(7, 7, -1, 0, 0);
        chk("dual_err", 32'(ec), 32'd1);

        // START pulsed mid-run is ignored
        do_start();
        send_beat(m_lfsr, 0, 4'd0);
        tvalid = 0;
        start = 1;
        idle_tick();
        start = 0;
        run_stream(-1, -1, -1, 0, 0);
        chk("start_ign_beat", 32'(bc), 32'd16);
        chk("start_ign_pass", 32'(pass), 32'd1);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            do_start();
            run_stream(-1, -1, -1, 1, 25);
            if (m_recv) do_reset();
        end

        // Reset in the middle of a packet, then a clean run
        do_start();
        send_beat(m_lfsr, 0, 4'd0);
        send_beat(m_lfsr, 0, 4'd0);
        tvalid = 0;
        do_reset();
        chk("post_rst_beat", 32'(bc), 32'd0);
        do_start();
        run_stream(-1, -1, -1, 0, 0);
        chk("post_rst_pass", 32'(pass), 32'd1);

        // Periodic stall instance, TVALID held high
        sel = 1;
        stall_every = 2;
        m_recv = 0;
        model_clear();
        do_start();
        run_stream(-1, -1, -1, 0, 0);
        chk("stall_pass", 32'(pass), 32'd1);
        chk("stall_beat", 32'(bc), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/num_check.md
NUM_CHECK -- requirements
Module: num_check

Interface
Parameters:
REQ-001 The block SHALL have parameter TDATAW, default 32, which sets the AXI-Stream data width.
REQ-002 The block SHALL have parameter TDESTW, default 4, which sets the AXI-Stream destination width.
REQ-003 The block SHALL have parameter LFSR_DW, default 32, which sets the LFSR width (LFSR_DW <= TDATAW); only TDATA[LFSR_DW-1:0] is compared.
REQ-004 The block SHALL have parameter LFSR_DEFAULT, default 32'h0000_0001, which is the LFSR seed and the first expected word.
REQ-005 The block SHALL have parameter LFSR_TAPS, default 32'h8020_0003, which is the feedback tap mask.
REQ-006 The block SHALL have parameter PKT_LEN, default 4, which sets the beats per packet (>= 1).
REQ-007 The block SHALL have parameter NUM_PKTS, default 4, which sets the number of packets per run (>= 1).
REQ-008 The block SHALL have parameter MY_DEST, default 0, which is the expected TDEST.
REQ-009 The block SHALL have parameter STALL_EVERY, default 0, which sets the number of accepted beats between forced one-cycle TREADY drops (0 = never).
Ports:
REQ-010 The block SHALL have port CLK, input, width 1: the single clock, with all logic on its rising edge.
REQ-011 The block SHALL have port RST, input, width 1: the reset, asynchronous and active-high.
REQ-012 The block SHALL have port START, input, width 1: a level that arms a run.
REQ-013 The block SHALL have ports AXIS_S_TVALID (in, 1), AXIS_S_TREADY (out, 1), AXIS_S_TDATA (in, TDATAW), AXIS_S_TLAST (in, 1) and AXIS_S_TDEST (in, TDESTW): the AXI-Stream slave.
REQ-014 The block SHALL have output ports PKT_COUNT (16), BEAT_COUNT (16) and ERR_COUNT (16): packets completed, beats accepted, and errors (saturating).
REQ-015 The block SHALL have output ports DONE (1), PASS (1) and FIRST_ERR_DATA (TDATAW): run complete, run complete with zero errors, and TDATA of the first erroneous beat.

Function
REQ-016 The FSM SHALL have states IDLE, RECV and DONE.
REQ-017 A START level seen in IDLE or DONE SHALL, on that edge, move the FSM to RECV, load the LFSR with LFSR_DEFAULT, and clear all counters, FIRST_ERR_DATA, DONE and PASS.
REQ-018 START SHALL be ignored while in RECV.
REQ-019 AXIS_S_TREADY SHALL be combinational and equal (state==RECV) && !stall_q; it SHALL NOT depend on TVALID.
REQ-020 A beat SHALL be accepted on a rising edge only when TVALID && TREADY; TDATA, TLAST and TDEST SHALL be sampled only then.
REQ-021 On every accepted beat the LFSR SHALL advance to {cur[LFSR_DW-2:0], ^(cur & LFSR_TAPS)}, regardless of whether a mismatch occurred, so that one error does not cascade.
REQ-022 An accepted beat SHALL be a data error if TDATA[LFSR_DW-1:0] != cur.
REQ-023 An accepted beat SHALL be a dest error if TDEST != MY_DEST.
REQ-024 An accepted beat SHALL be a framing error if TLAST != (beat_idx == PKT_LEN-1).
REQ-025 A beat with one or more of these errors SHALL increment ERR_COUNT by exactly 1, and ERR_COUNT SHALL saturate at 16'hFFFF.
REQ-026 FIRST_ERR_DATA SHALL capture TDATA on the first erroneous beat of a run and SHALL hold that value until the next START or reset.
REQ-027 beat_idx SHALL increment per accepted beat and return to 0 on an accepted TLAST, even when TLAST arrives early.
REQ-028 A beat with beat_idx == PKT_LEN-1 and TLAST low SHALL roll beat_idx to 0 without incrementing PKT_COUNT.
REQ-029 PKT_COUNT SHALL increment on each accepted TLAST beat.
REQ-030 BEAT_COUNT SHALL increment on every accepted beat and SHALL wrap at 16 bits.
REQ-031 The FSM SHALL go from RECV to DONE on the edge that accepts the TLAST making PKT_COUNT == NUM_PKTS, so TREADY is low from the next cycle.
REQ-032 In DONE, DONE SHALL be 1 and PASS SHALL be (ERR_COUNT == 0); both SHALL be registered and valid the cycle after the final beat.
REQ-033 The stall counter SHALL count accepted beats when STALL_EVERY != 0; on reaching STALL_EVERY it SHALL set stall_q for exactly one cycle and then restart.
REQ-034 The stall counter SHALL be cleared on START.
REQ-035 All status outputs SHALL be registered; the counters SHALL reflect an accepted beat on the cycle after acceptance.

Reset
REQ-036 RST high SHALL asynchronously force state=IDLE, LFSR=LFSR_DEFAULT, stall_q=0, beat_idx=0, PKT_COUNT=BEAT_COUNT=ERR_COUNT=0, FIRST_ERR_DATA=0, DONE=0, PASS=0 and TREADY=0.
REQ-037 A reset asserted mid-packet SHALL discard the partial packet, and the block SHALL stay in IDLE after release until START.

Verification
REQ-038 Defaults, START, and 16 beats 1,3,6,... with TLAST on every 4th beat and TDEST=0 -> PKT_COUNT=4, BEAT_COUNT=16, ERR_COUNT=0, DONE=1, PASS=1, TREADY=0.
REQ-039 Beat 2 of packet 0 sent as 32'hDEAD_BEEF, all other beats correct -> ERR_COUNT=1, FIRST_ERR_DATA=32'hDEAD_BEEF, PASS=0, and later beats are not flagged.
REQ-040 TLAST on beat 2 of packet 0 -> framing error counted, PKT_COUNT increments, and beat_idx restarts at 0.
REQ-041 TDEST=1 on one beat -> ERR_COUNT=1; a data and dest error on the same beat -> ERR_COUNT still increments by only 1.
REQ-042 STALL_EVERY=2 with TVALID held high -> TREADY is low exactly one cycle after every 2nd acceptance, and the sequence checks clean.
REQ-043 RST pulsed after 2 beats, then START -> all counters read 0, and a full clean run gives PASS=1.
